// File: rtl/ws2812b_pkg.sv
// Shared types and register map for the ws2812b driver and its bus sequencer.
package ws2812b_pkg;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    localparam logic [1:0] REG_COMMAND = 2'd0;
    localparam logic [1:0] REG_B       = 2'd1;
    localparam logic [1:0] REG_G       = 2'd2;
    localparam logic [1:0] REG_R       = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    // Fields go out as COMMAND, R, G, B; the driver merges each colour into its buffer.
    function automatic logic [1:0] field_address(input logic [1:0] field);
        logic [1:0] addr;
        case (field)
            2'd0:    addr = REG_COMMAND;
            2'd1:    addr = REG_R;
            2'd2:    addr = REG_G;
            default: addr = REG_B;
        endcase
        return addr;
    endfunction

    function automatic logic [7:0] field_data(input logic [1:0] field,
                                              input logic [7:0] index,
                                              input pixel_t     pixel);
        logic [7:0] data;
        case (field)
            2'd0:    data = index;
            2'd1:    data = pixel.r;
            2'd2:    data = pixel.g;
            default: data = pixel.b;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/ws2812b_pixel_sequencer_rr_arbiter.sv
// Round-robin arbiter, search starts one past last_grant; purely combinational, zero latency.
// Backpressure: none; grant is zero when no request is present.
module rr_arbiter #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  request,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_index
);

    int          cand;
    logic [IW-1:0] cand_idx;
    logic        found;

    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 1; off <= N; off++) begin
            cand     = (int'(last_grant) + off) % N;
            cand_idx = IW'(cand);
            if (!found && request[cand_idx]) begin
                grant[cand_idx] = 1'b1;
                grant_index     = cand_idx;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ws2812b_pixel_sequencer.sv
// Arbitrates pixel sources and writes COMMAND,R,G,B to the ws2812b register bus; 9 cycles/pixel with a 1-cycle driver.
// Backpressure: req_ready only in idle, one requester at a time; each write waits for reg_response or times out.
module ws2812b_pixel_sequencer
    import ws2812b_pkg::*;
#(
    parameter int  NUM_REQUESTERS = 2,
    parameter int  NUMBER_OF_LEDS = 16,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int GW             = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQUESTERS-1:0]    req_valid,
    output logic [NUM_REQUESTERS-1:0]    req_ready,
    input  logic [NUM_REQUESTERS*8-1:0]  req_index,
    input  logic [NUM_REQUESTERS*24-1:0] req_pixel,
    output logic [1:0]                   reg_address,
    output logic                         reg_is_write,
    output logic                         reg_request,
    output logic [7:0]                   reg_write_data,
    input  logic                         reg_response,
    output logic                         busy,
    output logic [GW-1:0]                grant_id,
    output logic                         err_range,
    output logic                         err_timeout,
    input  logic                         error_clear
);

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] LED_LIMIT = NUMBER_OF_LEDS;

    state_t        state;
    logic [1:0]    field;
    logic [1:0]    next_field;
    logic [GW-1:0] last_grant;
    logic [7:0]    cur_index;
    pixel_t        cur_pixel;
    logic [TW-1:0] timer;

    logic [NUM_REQUESTERS-1:0] arb_grant;
    logic [GW-1:0]             arb_idx;
    logic [7:0]                idx_arr [NUM_REQUESTERS];
    pixel_t                    pix_arr [NUM_REQUESTERS];
    logic [7:0]                sel_index;
    pixel_t                    sel_pixel;
    logic                      accept;
    logic                      in_range;

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
        assign idx_arr[i] = req_index[8*i +: 8];
        assign pix_arr[i] = req_pixel[24*i +: 24];
    end

    rr_arbiter #(
        .N (NUM_REQUESTERS)
    ) u_arbiter (
        .request     (req_valid),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_index (arb_idx)
    );

    assign req_ready  = (state == S_IDLE) ? arb_grant : '0;
    assign accept     = |(req_valid & req_ready);
    assign sel_index  = idx_arr[arb_idx];
    assign sel_pixel  = pix_arr[arb_idx];
    assign in_range   = {24'd0, sel_index} < LED_LIMIT;
    assign next_field = field + 2'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            field          <= 2'd0;
            last_grant     <= GW'(NUM_REQUESTERS - 1);
            grant_id       <= '0;
            cur_index      <= '0;
            cur_pixel      <= '0;
            timer          <= '0;
            reg_request    <= 1'b0;
            reg_is_write   <= 1'b0;
            reg_address    <= '0;
            reg_write_data <= '0;
            busy           <= 1'b0;
            err_range      <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            reg_request  <= 1'b0;
            reg_is_write <= 1'b0;
            // Set events below are written later and so override this clear.
            if (error_clear) begin
                err_range   <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_id   <= arb_idx;
                        last_grant <= arb_idx;
                        cur_index  <= sel_index;
                        cur_pixel  <= sel_pixel;
                        if (in_range) begin
                            field          <= 2'd0;
                            state          <= S_ISSUE;
                            busy           <= 1'b1;
                            reg_request    <= 1'b1;
                            reg_is_write   <= 1'b1;
                            reg_address    <= field_address(2'd0);
                            reg_write_data <= field_data(2'd0, sel_index, sel_pixel);
                        end else begin
                            err_range <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (reg_response) begin
                        if (field == 2'd3) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            field          <= next_field;
                            state          <= S_ISSUE;
                            reg_request    <= 1'b1;
                            reg_is_write   <= 1'b1;
                            reg_address    <= field_address(next_field);
                            reg_write_data <= field_data(next_field, cur_index, cur_pixel);
                        end
                    end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        // Remaining fields are abandoned; the driver keeps a partial pixel.
                        err_timeout <= 1'b1;
                        state       <= S_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812b_pixel_sequencer.sv
// Scoreboard bench: stimulus pushes expected grants and bus writes, negedge monitors pop and compare.
module tb_ws2812b_pixel_sequencer;

    logic        clock;
    logic        resetn;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_index;
    logic [47:0] req_pixel;
    logic [1:0]  reg_address;
    logic        reg_is_write;
    logic        reg_request;
    logic [7:0]  reg_write_data;
    logic        reg_response;
    logic        busy;
    logic [0:0]  grant_id;
    logic        err_range;
    logic        err_timeout;
    logic        error_clear;

    logic auto_resp, resp_arm, auto_r, stray;
    assign reg_response = auto_r | stray;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    typedef struct {
        int id;
        int cyc;
    } gr_t;

    wr_t exp_wr[$];
    gr_t exp_gr[$];
    wr_t e_wr;
    gr_t e_gr;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int c;

    ws2812b_pixel_sequencer #(
        .NUM_REQUESTERS (2),
        .NUMBER_OF_LEDS (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_index      (req_index),
        .req_pixel      (req_pixel),
        .reg_address    (reg_address),
        .reg_is_write   (reg_is_write),
        .reg_request    (reg_request),
        .reg_write_data (reg_write_data),
        .reg_response   (reg_response),
        .busy           (busy),
        .grant_id       (grant_id),
        .err_range      (err_range),
        .err_timeout    (err_timeout),
        .error_clear    (error_clear)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_grant(input int id, input int at);
        gr_t g;
        g.id  = id;
        g.cyc = at;
        exp_gr.push_back(g);
    endtask

    task automatic push_wr(input logic [1:0] a, input logic [7:0] d, input int at);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.cyc  = at;
        exp_wr.push_back(w);
    endtask

    // pixel is {g,r,b}; writes COMMAND, R(3), G(2), B(1) two cycles apart.
    task automatic push_pixel(input int at, input logic [7:0] idx, input logic [23:0] pix);
        push_wr(2'd0, idx,        at + 1);
        push_wr(2'd3, pix[15:8],  at + 3);
        push_wr(2'd2, pix[23:16], at + 5);
        push_wr(2'd1, pix[7:0],   at + 7);
    endtask

    // Driver model: responds in the cycle after each request.
    always @(negedge clock) begin
        if (auto_resp && resetn && reg_request) resp_arm = 1'b1;
    end
    always @(posedge clock) begin
        #1;
        auto_r   = resp_arm;
        resp_arm = 1'b0;
    end

    always @(negedge clock) begin
        if (resetn && reg_request) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h at cycle %0d, required no write",
                         reg_address, reg_write_data, cyc);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("wr_addr",     {30'd0, reg_address}, {30'd0, e_wr.addr});
                chk("wr_data",     {24'd0, reg_write_data}, {24'd0, e_wr.data});
                chk("wr_cycle",    cyc, e_wr.cyc);
                chk("wr_is_write", {31'd0, reg_is_write}, 32'd1);
            end
        end
        if (resetn && |(req_valid & req_ready)) begin
            if (exp_gr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: got ready=%b at cycle %0d, required none", req_ready, cyc);
            end else begin
                e_gr = exp_gr.pop_front();
                chk("grant_onehot", {30'd0, req_ready}, (32'd1 << e_gr.id));
                chk("grant_cycle",  cyc, e_gr.cyc);
            end
        end
    end

    initial begin
        resetn      = 1'b0;
        req_valid   = '0;
        req_index   = '0;
        req_pixel   = '0;
        error_clear = 1'b0;
        auto_resp   = 1'b1;
        resp_arm    = 1'b0;
        auto_r      = 1'b0;
        stray       = 1'b0;

        #2;
        chk("rst_req_ready",   {30'd0, req_ready}, 32'd0);
        chk("rst_reg_request", {31'd0, reg_request}, 32'd0);
        chk("rst_reg_address", {30'd0, reg_address}, 32'd0);
        chk("rst_write_data",  {24'd0, reg_write_data}, 32'd0);
        chk("rst_is_write",    {31'd0, reg_is_write}, 32'd0);
        chk("rst_busy",        {31'd0, busy}, 32'd0);
        chk("rst_grant_id",    {31'd0, grant_id}, 32'd0);
        chk("rst_err_range",   {31'd0, err_range}, 32'd0);
        chk("rst_err_timeout", {31'd0, err_timeout}, 32'd0);
        tick(1);
        resetn = 1'b1;
        tick(2);

        // Single pixel: requester 0, index 5, pixel 0x112233.
        c = cyc;
        req_valid       = 2'b01;
        req_index[7:0]  = 8'd5;
        req_pixel[23:0] = 24'h112233;
        push_grant(0, c);
        push_pixel(c, 8'd5, 24'h112233);
        tick(1);
        req_valid = '0;
        tick(7);
        chk("single_busy_c8", {31'd0, busy}, 32'd1);
        tick(1);
        chk("single_busy_c9", {31'd0, busy}, 32'd0);
        chk("single_grant_id", {31'd0, grant_id}, 32'd0);

        // Contention from reset: grants alternate 0,1,0,1 nine cycles apart.
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(1);
        c = cyc;
        req_valid  = 2'b11;
        req_index  = {8'd2, 8'd1};
        req_pixel  = {24'h0F1E2D, 24'hA1B2C3};
        for (int k = 0; k < 4; k++) begin
            push_grant(k % 2, c + 9 * k);
            push_pixel(c + 9 * k, (k % 2) ? 8'd2 : 8'd1, (k % 2) ? 24'h0F1E2D : 24'hA1B2C3);
        end
        tick(28);
        req_valid = '0;
        tick(8);
        chk("contend_busy_end", {31'd0, busy}, 32'd0);
        chk("contend_grant_id", {31'd0, grant_id}, 32'd1);

        // Out-of-range index is dropped in one cycle and flagged.
        c = cyc;
        req_valid       = 2'b10;
        req_index[15:8] = 8'd16;
        push_grant(1, c);
        tick(1);
        req_valid = '0;
        chk("range_err_set", {31'd0, err_range}, 32'd1);
        chk("range_busy",    {31'd0, busy}, 32'd0);
        error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
        chk("range_err_clr", {31'd0, err_range}, 32'd0);
        // Set and clear in the same cycle: set wins.
        c = cyc;
        req_valid      = 2'b01;
        req_index[7:0] = 8'd200;
        error_clear    = 1'b1;
        push_grant(0, c);
        tick(1);
        req_valid   = '0;
        error_clear = 1'b0;
        chk("range_set_wins", {31'd0, err_range}, 32'd1);
        error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
        chk("range_err_clr2", {31'd0, err_range}, 32'd0);

        // Timeout: driver silent, err_timeout 8 cycles after entering S_WAIT.
        auto_resp = 1'b0;
        c = cyc;
        req_valid       = 2'b01;
        req_index[7:0]  = 8'd3;
        req_pixel[23:0] = 24'h445566;
        push_grant(0, c);
        push_wr(2'd0, 8'd3, c + 1);
        tick(1);
        req_valid = '0;
        tick(8);
        chk("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
        chk("tmo_busy_c9", {31'd0, busy}, 32'd1);
        tick(1);
        chk("tmo_err_set", {31'd0, err_timeout}, 32'd1);
        chk("tmo_idle",    {31'd0, busy}, 32'd0);
        error_clear = 1'b1;
        tick(1);
        error_clear = 1'b0;
        chk("tmo_err_clr", {31'd0, err_timeout}, 32'd0);
        auto_resp = 1'b1;

        // Stray responses while idle and alongside requests are ignored; index 15 is in range.
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        c = cyc;
        req_valid        = 2'b10;
        req_index[15:8]  = 8'd15;
        req_pixel[47:24] = 24'h00FF80;
        push_grant(1, c);
        push_pixel(c, 8'd15, 24'h00FF80);
        stray = 1'b1;
        tick(1);
        req_valid = '0;
        tick(1);
        stray = 1'b0;
        tick(1);
        stray = 1'b1;
        tick(1);
        stray = 1'b0;
        tick(4);
        chk("stray_busy_c8", {31'd0, busy}, 32'd1);
        tick(1);
        chk("stray_busy_c9", {31'd0, busy}, 32'd0);

        // Reset during field 2 drops the request at once; requester 0 wins after release.
        c = cyc;
        req_valid        = 2'b10;
        req_index[15:8]  = 8'd9;
        req_pixel[47:24] = 24'h123456;
        push_grant(1, c);
        push_wr(2'd0, 8'd9,  c + 1);
        push_wr(2'd3, 8'h34, c + 3);
        tick(1);
        req_valid = '0;
        tick(4);
        chk("mid_req_before", {31'd0, reg_request}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_request", {31'd0, reg_request}, 32'd0);
        chk("mid_rst_busy",    {31'd0, busy}, 32'd0);
        tick(1);
        resetn = 1'b1;
        tick(1);
        c = cyc;
        req_valid = 2'b11;
        req_index = {8'd7, 8'd4};
        req_pixel = {24'hCAFE01, 24'h0A0B0C};
        push_grant(0, c);
        push_pixel(c, 8'd4, 24'h0A0B0C);
        tick(1);
        req_valid = '0;
        tick(8);
        chk("post_rst_busy",     {31'd0, busy}, 32'd0);
        chk("post_rst_grant_id", {31'd0, grant_id}, 32'd0);

        tick(3);
        chk("leftover_writes", exp_wr.size(), 32'd0);
        chk("leftover_grants", exp_gr.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
